// File: rtl/stereo_pkg.sv
// rtl/stereo_pkg.sv - shared pixel/frame constants and packed word type for the stereo path
package stereo_pkg;
    localparam int PIX_W           = 8;
    localparam int FRAME_W         = 640;
    localparam int FRAME_H         = 480;
    localparam int PIX_PER_WORD    = 8;
    localparam int WORDS_PER_FRAME = FRAME_W * FRAME_H / PIX_PER_WORD;
    localparam int WORD_W          = PIX_W * PIX_PER_WORD;

    typedef logic [PIX_W*PIX_PER_WORD-1:0] word_t;
endpackage

// File: rtl/pix_word_packer.sv
// rtl/pix_word_packer.sv - packs one camera's pixels into words and buffers them in a tagged FIFO
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   pix_i/valid_i/sof_i one pixel per cycle, sof_i marks pixel 0 of a frame
//   pop_i               consume the head word (only asserted when not empty)
//   word_o/tag_o        head word and its start-of-frame tag
//   empty_o             FIFO holds no word
//   drop_o              a completed word was discarded because the FIFO was full
//   resync_o            an SOF arrived mid-word and the partial word was discarded
module pix_word_packer
    import stereo_pkg::PIX_W;
#(
    parameter int PIX_PER_WORD = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PIX_W-1:0]              pix_i,
    input  logic                          valid_i,
    input  logic                          sof_i,
    input  logic                          pop_i,
    output logic [PIX_W*PIX_PER_WORD-1:0] word_o,
    output logic                          tag_o,
    output logic                          empty_o,
    output logic                          drop_o,
    output logic                          resync_o
);
    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);

    logic [LANE_W-1:0] lane_q, lane_d, lane_eff;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              tag_q, tag_d;
    logic [WORD_W:0]   mem_q [FIFO_DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [WORD_W:0]   fifo_wdata;
    logic              complete, full, push;

    always_comb begin
        // An SOF pixel always restarts the word at lane 0.
        lane_eff = sof_i ? '0 : lane_q;
        resync_o = valid_i && sof_i && (lane_q != '0);
        complete = valid_i && (lane_eff == LAST_LANE);
        shreg_d  = shreg_q;
        lane_d   = lane_q;
        tag_d    = tag_q;
        if (valid_i) begin
            // Shift in at the top so that after a full group the first pixel sits in the low byte;
            // stale bits of a discarded partial word are shifted out before the word completes.
            shreg_d = {pix_i, shreg_q[WORD_W-1:PIX_W]};
            lane_d  = complete ? '0 : lane_eff + LANE_W'(1);
            if (lane_eff == '0) begin
                tag_d = sof_i;
            end
        end
        fifo_wdata = {(lane_eff == '0) ? sof_i : tag_q, shreg_d};
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W])
                  && (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    // A simultaneous pop frees the slot being written, so a full FIFO still accepts.
    assign push    = complete && (!full || pop_i);
    assign drop_o  = complete && full && !pop_i;
    assign word_o  = mem_q[rd_ptr_q[ADDR_W-1:0]][WORD_W-1:0];
    assign tag_o   = mem_q[rd_ptr_q[ADDR_W-1:0]][WORD_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q   <= '0;
            shreg_q  <= '0;
            tag_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
            tag_q   <= tag_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= fifo_wdata;
        end
    end
endmodule

// File: rtl/stereo_pixel_packer.sv
// rtl/stereo_pixel_packer.sv - pairs packed left/right camera words for the stereo SAD accumulator
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   l_pix/l_valid/l_sof        left camera pixel stream
//   r_pix/r_valid/r_sof        right camera pixel stream
//   left_word/right_word       registered packed word pair, held between strobes
//   word_valid                 one-cycle strobe for a valid pair
//   word_idx                   pair index within the frame
//   frame_done                 strobes with the last pair of a frame
//   overflow                   sticky: a word was dropped on a full FIFO
//   misalign                   sticky: mid-word SOF or SOF tag mismatch between cameras
module stereo_pixel_packer
    import stereo_pkg::PIX_W;
#(
    parameter int PIX_PER_WORD    = stereo_pkg::PIX_PER_WORD,
    parameter int FIFO_DEPTH      = 4,
    parameter int WORDS_PER_FRAME = stereo_pkg::WORDS_PER_FRAME
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PIX_W-1:0]              l_pix,
    input  logic                          l_valid,
    input  logic                          l_sof,
    input  logic [PIX_W-1:0]              r_pix,
    input  logic                          r_valid,
    input  logic                          r_sof,
    output logic [PIX_W*PIX_PER_WORD-1:0] left_word,
    output logic [PIX_W*PIX_PER_WORD-1:0] right_word,
    output logic                          word_valid,
    output logic [15:0]                   word_idx,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          misalign
);
    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam logic [15:0] LAST_IDX = 16'(WORDS_PER_FRAME - 1);

    logic [WORD_W-1:0] l_fifo_word, r_fifo_word;
    logic              l_tag, r_tag, l_empty, r_empty;
    logic              l_drop, r_drop, l_resync, r_resync;
    logic              pop;
    logic [15:0]       idx_next;

    logic [WORD_W-1:0] left_word_q, right_word_q;
    logic              word_valid_q, frame_done_q, overflow_q, misalign_q;
    logic [15:0]       word_idx_q;

    pix_word_packer #(
        .PIX_PER_WORD (PIX_PER_WORD),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_left (
        .clk      (clk),
        .reset    (reset),
        .pix_i    (l_pix),
        .valid_i  (l_valid),
        .sof_i    (l_sof),
        .pop_i    (pop),
        .word_o   (l_fifo_word),
        .tag_o    (l_tag),
        .empty_o  (l_empty),
        .drop_o   (l_drop),
        .resync_o (l_resync)
    );

    pix_word_packer #(
        .PIX_PER_WORD (PIX_PER_WORD),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_right (
        .clk      (clk),
        .reset    (reset),
        .pix_i    (r_pix),
        .valid_i  (r_valid),
        .sof_i    (r_sof),
        .pop_i    (pop),
        .word_o   (r_fifo_word),
        .tag_o    (r_tag),
        .empty_o  (r_empty),
        .drop_o   (r_drop),
        .resync_o (r_resync)
    );

    // Downstream never stalls, so both heads are consumed as soon as both exist.
    assign pop = !l_empty && !r_empty;

    always_comb begin
        idx_next = '0;
        if (!l_tag && (word_idx_q != LAST_IDX)) begin
            idx_next = word_idx_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            left_word_q  <= '0;
            right_word_q <= '0;
            word_valid_q <= 1'b0;
            word_idx_q   <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            if (pop && (l_tag == r_tag)) begin
                left_word_q  <= l_fifo_word;
                right_word_q <= r_fifo_word;
                word_valid_q <= 1'b1;
                word_idx_q   <= idx_next;
                frame_done_q <= (idx_next == LAST_IDX);
            end
            overflow_q <= overflow_q | l_drop | r_drop;
            misalign_q <= misalign_q | l_resync | r_resync | (pop && (l_tag != r_tag));
        end
    end

    assign left_word  = left_word_q;
    assign right_word = right_word_q;
    assign word_valid = word_valid_q;
    assign word_idx   = word_idx_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign misalign   = misalign_q;
endmodule

// File: tb/tb_stereo_pixel_packer.sv
// tb/tb_stereo_pixel_packer.sv - self-checking bench for stereo_pixel_packer
module tb_stereo_pixel_packer;
    localparam int DEPTH = 4;
    localparam int WPF   = 4800;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  l_pix = '0, r_pix = '0;
    logic        l_valid = 1'b0, l_sof = 1'b0, r_valid = 1'b0, r_sof = 1'b0;
    logic [63:0] left_word, right_word;
    logic        word_valid, frame_done, overflow, misalign;
    logic [15:0] word_idx;

    stereo_pixel_packer #(
        .PIX_PER_WORD    (8),
        .FIFO_DEPTH      (DEPTH),
        .WORDS_PER_FRAME (WPF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .l_pix      (l_pix),
        .l_valid    (l_valid),
        .l_sof      (l_sof),
        .r_pix      (r_pix),
        .r_valid    (r_valid),
        .r_sof      (r_sof),
        .left_word  (left_word),
        .right_word (right_word),
        .word_valid (word_valid),
        .word_idx   (word_idx),
        .frame_done (frame_done),
        .overflow   (overflow),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model state: expected registered outputs after the most recent clock edge.
    logic [63:0] m_lw = '0, m_rw = '0;
    logic        m_valid = 1'b0, m_fd = 1'b0, m_ovf = 1'b0, m_mis = 1'b0;
    int          m_idx = 0;
    logic [64:0] lq[$];
    logic [64:0] rq[$];
    int          g_n[2] = '{0, 0};
    logic [63:0] g_w[2];
    logic        g_t[2];

    // Observation counters.
    int          pairs = 0, fd_cnt = 0, fd_idx = -1, last_idx = -1;
    logic [63:0] last_lw = '0, last_rw = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic model_cam(input int cam, input logic v, input logic s, input logic [7:0] p);
        logic [64:0] e;
        if (!v) return;
        if (s && g_n[cam] != 0) begin
            m_mis = 1'b1;
            g_n[cam] = 0;
        end
        if (g_n[cam] == 0) begin
            g_w[cam] = '0;
            g_t[cam] = s;
        end
        g_w[cam] = g_w[cam] | (64'(p) << (8 * g_n[cam]));
        g_n[cam]++;
        if (g_n[cam] == 8) begin
            g_n[cam] = 0;
            e = {g_t[cam], g_w[cam]};
            if (cam == 0) begin
                if (lq.size() < DEPTH) lq.push_back(e); else m_ovf = 1'b1;
            end else begin
                if (rq.size() < DEPTH) rq.push_back(e); else m_ovf = 1'b1;
            end
        end
    endtask

    // Advances the model across one clock edge given the inputs presented for that edge.
    // Pops use FIFO contents from before the edge, so they are taken first; the freed slot
    // then lets a same-edge push into a previously full FIFO succeed.
    task automatic model_step(input logic rst, input logic lv, input logic ls, input logic [7:0] lp,
                              input logic rv, input logic rs, input logic [7:0] rp);
        logic [64:0] le, re;
        if (rst) begin
            m_lw = '0; m_rw = '0; m_valid = 0; m_fd = 0; m_ovf = 0; m_mis = 0; m_idx = 0;
            lq.delete(); rq.delete();
            g_n[0] = 0; g_n[1] = 0;
            return;
        end
        m_valid = 1'b0;
        m_fd    = 1'b0;
        if (lq.size() > 0 && rq.size() > 0) begin
            le = lq.pop_front();
            re = rq.pop_front();
            if (le[64] == re[64]) begin
                m_valid = 1'b1;
                m_lw    = le[63:0];
                m_rw    = re[63:0];
                m_idx   = le[64] ? 0 : (m_idx + 1) % WPF;
                m_fd    = (m_idx == WPF - 1);
            end else begin
                m_mis = 1'b1;
            end
        end
        model_cam(0, lv, ls, lp);
        model_cam(1, rv, rs, rp);
    endtask

    task automatic check_outputs();
        vectors++;
        if (word_valid !== m_valid || frame_done !== m_fd || overflow !== m_ovf || misalign !== m_mis
            || word_idx !== 16'(m_idx) || left_word !== m_lw || right_word !== m_rw) begin
            miscompares++;
            $display("FAIL cycle%0d outputs: got v=%b l=%h r=%h idx=%0d fd=%b ovf=%b mis=%b, want v=%b l=%h r=%h idx=%0d fd=%b ovf=%b mis=%b",
                     cyc, word_valid, left_word, right_word, word_idx, frame_done, overflow, misalign,
                     m_valid, m_lw, m_rw, m_idx, m_fd, m_ovf, m_mis);
        end
        if (word_valid === 1'b1) begin
            pairs++;
            last_idx = int'(word_idx);
            last_lw  = left_word;
            last_rw  = right_word;
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_idx = int'(word_idx);
        end
    endtask

    task automatic step(input logic rst, input logic lv, input logic ls, input logic [7:0] lp,
                        input logic rv, input logic rs, input logic [7:0] rp);
        @(negedge clk);
        cyc++;
        check_outputs();
        reset = rst; l_valid = lv; l_sof = ls; l_pix = lp; r_valid = rv; r_sof = rs; r_pix = rp;
        model_step(rst, lv, ls, lp, rv, rs, rp);
    endtask

    task automatic idle(input logic rst);
        step(rst, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lw"}, left_word, 64'h0);
        chk({tag, "_rw"}, right_word, 64'h0);
        chk({tag, "_valid"}, 64'(word_valid), 64'h0);
        chk({tag, "_idx"}, 64'(word_idx), 64'h0);
        chk({tag, "_fd"}, 64'(frame_done), 64'h0);
        chk({tag, "_ovf"}, 64'(overflow), 64'h0);
        chk({tag, "_mis"}, 64'(misalign), 64'h0);
    endtask

    initial begin
        int p0, f0;

        // Reset state.
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chk_all_zero("reset");

        // Aligned streams: exact two-cycle latency after the 8th pixel.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i == 0, 8'(i + 1), 1'b1, i == 0, 8'(8'h11 + i));
        idle(1'b0);
        chk("aligned_c1_valid", 64'(word_valid), 64'h0);
        idle(1'b0);
        chk("aligned_valid", 64'(word_valid), 64'h1);
        chk("aligned_lw", left_word, 64'h0807060504030201);
        chk("aligned_rw", right_word, 64'h1817161514131211);
        chk("aligned_idx", 64'(word_idx), 64'h0);

        // Right stream 20 cycles behind the left one, three words each.
        p0 = pairs;
        for (int t = 0; t < 48; t++)
            step(1'b0, t < 24, t == 0, 8'(8'h40 + t), (t >= 20) && (t < 44), t == 20, 8'(8'h80 + t - 20));
        for (int k = 0; k < 4; k++) idle(1'b0);
        chk("skew_pairs", 64'(pairs - p0), 64'd3);
        chk("skew_ovf", 64'(overflow), 64'h0);
        chk("skew_last_idx", 64'(last_idx), 64'd2);

        // SOF on the 4th pixel of a left group discards the partial word.
        chk("pre_mis", 64'(misalign), 64'h0);
        for (int t = 0; t < 11; t++)
            step(1'b0, 1'b1, t == 3, 8'(8'h21 + t), t >= 3, t == 3, 8'(8'h31 + t - 3));
        idle(1'b0);
        idle(1'b0);
        chk("resync_valid", 64'(word_valid), 64'h1);
        chk("resync_lw", left_word, 64'h2B2A292827262524);
        chk("resync_rw", right_word, 64'h3837363534333231);
        chk("resync_mis", 64'(misalign), 64'h1);

        // Tag mismatch: the pair is dropped.
        idle(1'b1);
        idle(1'b0);
        p0 = pairs;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i == 0, 8'(8'hC0 + i), 1'b1, 1'b0, 8'(8'hD0 + i));
        idle(1'b0);
        idle(1'b0);
        chk("tagmis_valid", 64'(word_valid), 64'h0);
        chk("tagmis_mis", 64'(misalign), 64'h1);
        idle(1'b0);
        chk("tagmis_pairs", 64'(pairs - p0), 64'd0);

        // Overflow: five left words with the right camera idle.
        idle(1'b1);
        idle(1'b0);
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < 8; i++) step(1'b0, 1'b1, (w == 0) && (i == 0), 8'(w * 8 + i), 1'b0, 1'b0, 8'h00);
        idle(1'b0);
        chk("ovf_before", 64'(overflow), 64'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(32 + i), 1'b0, 1'b0, 8'h00);
        idle(1'b0);
        chk("ovf_after", 64'(overflow), 64'h1);
        p0 = pairs;
        for (int w = 0; w < 5; w++)
            for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, (w == 0) && (i == 0), 8'(8'h60 + w * 8 + i));
        for (int k = 0; k < 4; k++) idle(1'b0);
        chk("ovf_pairs", 64'(pairs - p0), 64'd4);
        chk("ovf_last_lw", last_lw, 64'h1F1E1D1C1B1A1918);
        chk("ovf_last_rw", last_rw, 64'h7F7E7D7C7B7A7978);

        // Reset mid-word with sticky flags set.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i == 0, 8'(8'hE0 + i), 1'b1, i == 0, 8'(8'hF0 + i));
        idle(1'b1);
        idle(1'b0);
        chk_all_zero("midreset");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i == 0, 8'(8'hA1 + i), 1'b1, i == 0, 8'(8'hB1 + i));
        idle(1'b0);
        idle(1'b0);
        chk("fresh_valid", 64'(word_valid), 64'h1);
        chk("fresh_lw", left_word, 64'hA8A7A6A5A4A3A2A1);
        chk("fresh_rw", right_word, 64'hB8B7B6B5B4B3B2B1);

        // Full frame followed by the next frame's first pair.
        idle(1'b1);
        idle(1'b0);
        p0 = pairs;
        f0 = fd_cnt;
        for (int w = 0; w <= WPF; w++)
            for (int i = 0; i < 8; i++)
                step(1'b0, 1'b1, ((w == 0) || (w == WPF)) && (i == 0), 8'(w * 3 + i),
                     1'b1, ((w == 0) || (w == WPF)) && (i == 0), 8'(w * 5 + i * 7));
        for (int k = 0; k < 4; k++) idle(1'b0);
        chk("frame_pairs", 64'(pairs - p0), 64'(WPF + 1));
        chk("frame_fd_count", 64'(fd_cnt - f0), 64'd1);
        chk("frame_fd_idx", 64'(fd_idx), 64'(WPF - 1));
        chk("frame_next_idx", 64'(last_idx), 64'h0);
        chk("frame_ovf", 64'(overflow), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
